// File: rtl/tron_layer_compositor_if.sv
// Raster/frame-buffer bus between the display timing block and the layer compositor.
interface tron_layer_compositor_if #(
    parameter int ADDR_W      = 18,
    parameter int WORD_W      = 16,
    parameter int PIX_W       = 4,
    parameter int NUM_PLAYERS = 2
) ();
    logic                         frame_clk;
    logic                         WE;
    logic [ADDR_W-1:0]            write_address;
    logic [WORD_W-1:0]            Data_In;
    logic [9:0]                   DrawX;
    logic [9:0]                   DrawY;
    logic [NUM_PLAYERS*PIX_W-1:0] Bike_Pix;
    logic [PIX_W-1:0]             color_enum;
    logic [NUM_PLAYERS-1:0]       collide;
    logic                         frame_done;

    modport master (
        output frame_clk, WE, write_address, Data_In, DrawX, DrawY, Bike_Pix,
        input  color_enum, collide, frame_done
    );

    modport slave (
        input  frame_clk, WE, write_address, Data_In, DrawX, DrawY, Bike_Pix,
        output color_enum, collide, frame_done
    );
endinterface

// File: rtl/tron_layer_compositor.sv
// Frame-buffer reader + bike sprite compositor with per-frame collision latch (TRON_COLLIDE_EN).
// Latency: colour 2 clocks after DrawX/DrawY; collide/frame_done 1 clock after frame_clk rise.
// Backpressure: none, one pixel accepted and emitted every clock.
module tron_layer_compositor #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PIX_W        = 4,
    parameter int PIX_PER_WORD = 2,
    parameter int LANE_STRIDE  = 8,
    parameter int WORD_W       = 16,
    parameter int NUM_PLAYERS  = 2,
    parameter logic [PIX_W-1:0] TRANSP_ENUM = 4'hF,
    parameter logic [PIX_W-1:0] BG_ENUM     = 4'h0
`ifdef TRON_COLLIDE_EN
    ,
    parameter logic [PIX_W-1:0] GRID_ENUM   = 4'h8
`endif
) (
    input logic                 Clk,
    input logic                 Reset,
    tron_layer_compositor_if.slave bus
);
    localparam int DEPTH     = H_RES * V_RES / PIX_PER_WORD;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int ROW_WORDS = H_RES / PIX_PER_WORD;
    localparam int LANE_W    = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    logic [WORD_W-1:0]            mem [DEPTH];
    logic [WORD_W-1:0]            rd_word;
    logic [ADDR_W-1:0]            rd_addr;
    logic [LANE_W-1:0]            lane_in;
    logic                         active_in;

    logic                         s1_active;
    logic [LANE_W-1:0]            s1_lane;
    logic [NUM_PLAYERS*PIX_W-1:0] s1_bike;

    logic [PIX_W-1:0]             fb_pix;
    logic [PIX_W-1:0]             comp;
    logic [NUM_PLAYERS-1:0]       opaque;

    logic                         fclk_q;
    logic                         frame_rise;
    logic                         frame_done_q;
    logic [PIX_W-1:0]             color_q;
    logic [NUM_PLAYERS-1:0]       collide_q;

    assign active_in = (32'(bus.DrawX) < H_RES) && (32'(bus.DrawY) < V_RES);
    // Off-screen rasters park the read on word 0 so the RAM is never indexed past its depth.
    assign rd_addr   = active_in ?
                       ADDR_W'(32'(bus.DrawX) / PIX_PER_WORD + 32'(bus.DrawY) * ROW_WORDS) : '0;
    assign lane_in   = LANE_W'(32'(bus.DrawX) % PIX_PER_WORD);

    // Read-before-write: a same-cycle read of the written word returns the old contents.
    always_ff @(posedge Clk) begin
        if (bus.WE) begin
            mem[bus.write_address] <= bus.Data_In;
        end
        rd_word <= mem[rd_addr];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_active <= 1'b0;
            s1_lane   <= '0;
            s1_bike   <= '0;
        end else begin
            s1_active <= active_in;
            s1_lane   <= lane_in;
            s1_bike   <= bus.Bike_Pix;
        end
    end

    // Walk players high to low so the lowest-index opaque bike ends up on top.
    always_comb begin
        opaque = '0;
        fb_pix = rd_word[32'(s1_lane) * LANE_STRIDE +: PIX_W];
        comp   = fb_pix;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (s1_bike[p*PIX_W +: PIX_W] != TRANSP_ENUM) begin
                opaque[p] = 1'b1;
                comp      = s1_bike[p*PIX_W +: PIX_W];
            end
        end
        if (!s1_active) begin
            comp = BG_ENUM;
        end
    end

    assign frame_rise = bus.frame_clk & ~fclk_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fclk_q       <= 1'b0;
            frame_done_q <= 1'b0;
            color_q      <= BG_ENUM;
        end else begin
            fclk_q       <= bus.frame_clk;
            frame_done_q <= frame_rise;
            color_q      <= comp;
        end
    end

`ifdef TRON_COLLIDE_EN
    logic [NUM_PLAYERS-1:0] hit;
    logic [NUM_PLAYERS-1:0] acc;
    logic                   fb_solid;

    always_comb begin
        hit      = '0;
        fb_solid = (fb_pix != BG_ENUM) && (fb_pix != GRID_ENUM);
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            hit[p] = s1_active && opaque[p] &&
                     (fb_solid || ((opaque & ~(NUM_PLAYERS'(1) << p)) != '0));
        end
    end

    // A hit landing on the frame edge seeds the new accumulator rather than the reported frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc       <= '0;
            collide_q <= '0;
        end else if (frame_rise) begin
            collide_q <= acc;
            acc       <= hit;
        end else begin
            acc       <= acc | hit;
        end
    end
`else
    assign collide_q = '0;
`endif

    assign bus.color_enum = color_q;
    assign bus.collide    = collide_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_tron_layer_compositor.sv
// Vector table + scoreboard bench for the Tron layer compositor.
module tb_tron_layer_compositor;
`ifdef TRON_COLLIDE_EN
    localparam bit COLLIDE_EN = 1'b1;
`else
    localparam bit COLLIDE_EN = 1'b0;
`endif

    typedef struct {
        int         x;
        int         y;
        logic [7:0] bikes;
        logic [3:0] color;
        logic [1:0] hit;
    } vec_t;

    typedef struct {
        int         due;
        logic [3:0] color;
        string      name;
    } sb_t;

    logic  clk;
    logic  rst;
    int    cyc;
    int    n_checks;
    int    n_errors;
    int    fd_cnt;
    vec_t  vt [13];
    sb_t   sb [$];

    tron_layer_compositor_if #(.ADDR_W(18), .WORD_W(16), .PIX_W(4), .NUM_PLAYERS(2)) bus ();

    tron_layer_compositor dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        sb_t e;
        if (bus.frame_done === 1'b1) fd_cnt++;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) check({e.name, "_late"}, 32'(cyc), 32'(e.due));
            else              check(e.name, 32'(bus.color_enum), 32'(e.color));
        end
    end

    task automatic idle();
        bus.DrawX    = 10'd700;
        bus.DrawY    = 10'd0;
        bus.Bike_Pix = 8'hFF;
    endtask

    task automatic drive(input int x, input int y, input logic [7:0] bikes,
                         input logic [3:0] exp, input string name);
        sb_t e;
        bus.DrawX    = 10'(x);
        bus.DrawY    = 10'(y);
        bus.Bike_Pix = bikes;
        e.due   = cyc + 2;
        e.color = exp;
        e.name  = name;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [15:0] data);
        bus.WE            = 1'b1;
        bus.write_address = 18'(addr);
        bus.Data_In       = data;
        @(posedge clk); #1;
        bus.WE            = 1'b0;
    endtask

    task automatic frame_edge(input logic [1:0] exp_col, input string name);
        int fd0;
        fd0 = fd_cnt;
        idle();
        bus.frame_clk = 1'b1;
        @(posedge clk); #1;
        check({name, "_done"}, 32'(bus.frame_done), 32'd1);
        check({name, "_collide"}, 32'(bus.collide), COLLIDE_EN ? 32'(exp_col) : 32'd0);
        repeat (3) @(posedge clk);
        #1;
        bus.frame_clk = 1'b0;
        @(posedge clk); #1;
        check({name, "_pulses"}, 32'(fd_cnt - fd0), 32'd1);
        check({name, "_hold"}, 32'(bus.collide), COLLIDE_EN ? 32'(exp_col) : 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_acc;
        cyc = 0; n_checks = 0; n_errors = 0; fd_cnt = 0;

        //          x    y    {b1,b0} colour hit
        vt[0]  = '{0,   0,   8'hFF, 4'h3, 2'b00};
        vt[1]  = '{1,   0,   8'hFF, 4'h5, 2'b00};
        vt[2]  = '{2,   0,   8'hF6, 4'h6, 2'b00};
        vt[3]  = '{3,   0,   8'hF3, 4'h3, 2'b00};
        vt[4]  = '{700, 0,   8'h63, 4'h0, 2'b00};
        vt[5]  = '{640, 0,   8'hFF, 4'h0, 2'b00};
        vt[6]  = '{0,   480, 8'hFF, 4'h0, 2'b00};
        vt[7]  = '{639, 479, 8'hFF, 4'h7, 2'b00};
        vt[8]  = '{638, 479, 8'hFF, 4'h0, 2'b00};
        vt[9]  = '{1,   1,   8'hFF, 4'hA, 2'b00};
        vt[10] = '{4,   0,   8'h2F, 4'h2, 2'b10};
        vt[11] = '{0,   1,   8'h76, 4'h6, 2'b11};
        vt[12] = '{5,   0,   8'hF3, 4'h3, 2'b01};

        rst = 1'b1;
        bus.WE = 1'b0; bus.write_address = '0; bus.Data_In = '0; bus.frame_clk = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_color", 32'(bus.color_enum), 32'h0);
        check("rst_collide", 32'(bus.collide), 32'h0);
        check("rst_done", 32'(bus.frame_done), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        wr(0, 16'h0503);
        wr(1, 16'h0800);
        wr(2, 16'h050C);
        wr(320, 16'h0A00);
        wr(153599, 16'h0700);

        // Three frames: no hits, both players hit, player 0 hits the trail.
        exp_acc = 2'b00;
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].x, vt[i].y, vt[i].bikes, vt[i].color, $sformatf("vec%0d", i));
            exp_acc |= vt[i].hit;
        end
        drain();
        frame_edge(exp_acc, "frame1");
        exp_acc = 2'b00;
        for (int i = 10; i < 12; i++) begin
            drive(vt[i].x, vt[i].y, vt[i].bikes, vt[i].color, $sformatf("vec%0d", i));
            exp_acc |= vt[i].hit;
        end
        drain();
        frame_edge(exp_acc, "frame2");
        drive(vt[12].x, vt[12].y, vt[12].bikes, vt[12].color, "vec12");
        drain();
        frame_edge(vt[12].hit, "frame3");

        // Hit resolved in the same cycle as the frame_clk rise.
        drive(1, 0, 8'hF3, 4'h3, "edge_hit_pix");
        frame_edge(2'b00, "edge_hit_old");
        drain();
        frame_edge(2'b01, "edge_hit_new");

        // Read of a word being written in the same cycle sees old data.
        bus.WE = 1'b1; bus.write_address = 18'd2; bus.Data_In = 16'h0B0B;
        drive(4, 0, 8'hFF, 4'hC, "wr_old");
        bus.WE = 1'b0;
        drive(4, 0, 8'hFF, 4'hB, "wr_new");
        drain();

        // Mid-frame reset with collide and accumulator both set.
        drive(0, 1, 8'h76, 4'h6, "pre_rst_pix");
        drain();
        frame_edge(2'b11, "pre_rst_frame");
        drive(0, 1, 8'h76, 4'h6, "pre_rst_pix2");
        drain();
        bus.DrawX = 10'd0; bus.DrawY = 10'd0; bus.Bike_Pix = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_color", 32'(bus.color_enum), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_color", 32'(bus.color_enum), 32'h0);
        check("rst_mid_collide", 32'(bus.collide), 32'h0);
        check("rst_mid_done", 32'(bus.frame_done), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drain();
        frame_edge(2'b00, "post_rst_frame");
        drive(0, 0, 8'hFF, 4'h3, "ram_kept0");
        drive(1, 0, 8'hFF, 4'h5, "ram_kept1");
        drain();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
